// File: rtl/imm_pkg.sv
// imm_pkg: shared immediate-format encoding and RV32I/RV64I major opcodes
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_SHIFT = 3'd2,
        FMT_S     = 3'd3,
        FMT_B     = 3'd4,
        FMT_U     = 3'd5,
        FMT_J     = 3'd6,
        FMT_ZIMM  = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational immediate extraction and format decode to XLEN bits
// IMM_ZICSR_EN adds the CSR-immediate (zimm) format for CSRRWI/CSRRSI/CSRRCI
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic               is_shift;
    logic [5:0]         shamt;
    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [31:0] imm_j;

    // funct3 001 (SLLI) and 101 (SRLI/SRAI) carry a shift amount, not an immediate
    assign is_shift = inst[13:12] == 2'b01;
    assign shamt    = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};
    assign imm_i    = {{20{inst[31]}}, inst[31:20]};
    assign imm_s    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u    = {inst[31:12], 12'b0};
    assign imm_j    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (inst[6:0])
            OP_LOAD, OP_JALR: begin
                fmt = FMT_I;
                imm = XLEN'(imm_i);
            end
            OP_IMM: begin
                fmt = is_shift ? FMT_SHIFT : FMT_I;
                imm = is_shift ? XLEN'(shamt) : XLEN'(imm_i);
            end
            OP_STORE: begin
                fmt = FMT_S;
                imm = XLEN'(imm_s);
            end
            OP_BRANCH: begin
                fmt = FMT_B;
                imm = XLEN'(imm_b);
            end
            OP_LUI, OP_AUIPC: begin
                fmt = FMT_U;
                imm = XLEN'(imm_u);
            end
            OP_JAL: begin
                fmt = FMT_J;
                imm = XLEN'(imm_j);
            end
            OP_SYSTEM: begin
`ifdef IMM_ZICSR_EN
                fmt = inst[14] ? FMT_ZIMM : FMT_NONE;
                imm = inst[14] ? XLEN'(inst[19:15]) : '0;
`else
                fmt = FMT_NONE;
`endif
            end
            OP_REG, OP_FENCE: fmt = FMT_NONE;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a 2-entry skid buffer and flush
// Build option IMM_ZICSR_EN is honoured by the imm_decode stage
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst_code,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output imm_fmt_e         imm_fmt,
    output logic             imm_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } imm_entry_t;

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;
    imm_entry_t      dec;
    imm_entry_t      main_q;
    imm_entry_t      skid_q;
    logic            main_v;
    logic            skid_v;
    logic            accept;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (inst_code),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign dec    = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: in_tag};
    assign accept = in_valid && in_ready;

    // Skid is only ever filled while main is held, so accept and skid_v never coincide
    always_ff @(posedge clk) begin
        if (reset) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (!main_v || out_ready) begin
            main_v <= skid_v || accept;
            main_q <= skid_v ? skid_q : accept ? dec : main_q;
            skid_v <= 1'b0;
        end else if (accept) begin
            skid_v <= 1'b1;
            skid_q <= dec;
        end
    end

    assign in_ready    = !skid_v;
    assign out_valid   = main_v;
    assign imm_out     = main_q.imm;
    assign imm_fmt     = main_q.fmt;
    assign imm_illegal = main_q.illegal;
    assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: table vectors, handshake corner sequences and random traffic against a queue model
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] inst_code = '0;
    logic [4:0]  in_tag = '0;

    logic        in_ready, out_valid, imm_illegal;
    logic [31:0] imm_out;
    imm_fmt_e    imm_fmt;
    logic [4:0]  out_tag;

    logic        in_ready64, out_valid64, imm_illegal64;
    logic [63:0] imm_out64;
    imm_fmt_e    imm_fmt64;
    logic [4:0]  out_tag64;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst_code(inst_code), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .imm_out(imm_out), .imm_fmt(imm_fmt), .imm_illegal(imm_illegal), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .inst_code(inst_code), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
        .imm_out(imm_out64), .imm_fmt(imm_fmt64), .imm_illegal(imm_illegal64), .out_tag(out_tag64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } ref_t;

    // Reference decode built from field values and arithmetic scaling
    function automatic ref_t model(input logic [31:0] i, input bit x64);
        longint     v = 0;
        logic [2:0] f = 3'd0;
        logic       ill = 1'b0;
        case (i[6:0])
            7'h03, 7'h67: begin f = 3'd1; v = longint'($signed(i[31:20])); end
            7'h13:
                if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin
                    f = 3'd2;
                    v = x64 ? longint'(i[25:20]) : longint'(i[24:20]);
                end else begin
                    f = 3'd1;
                    v = longint'($signed(i[31:20]));
                end
            7'h23: begin f = 3'd3; v = longint'($signed({i[31:25], i[11:7]})); end
            7'h63: begin f = 3'd4; v = longint'($signed({i[31], i[7], i[30:25], i[11:8]})) <<< 1; end
            7'h37, 7'h17: begin f = 3'd5; v = longint'($signed(i[31:12])) <<< 12; end
            7'h6F: begin f = 3'd6; v = longint'($signed({i[31], i[19:12], i[20], i[30:21]})) <<< 1; end
            7'h33, 7'h0F: f = 3'd0;
            7'h73: begin
`ifdef IMM_ZICSR_EN
                if (i[14]) begin f = 3'd7; v = longint'(i[19:15]); end
`else
                f = 3'd0;
`endif
            end
            default: ill = 1'b1;
        endcase
        return '{imm: v, fmt: f, ill: ill};
    endfunction

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [4:0]  tag;
    } exp_t;

    exp_t q[$];
    bit   armed = 1'b0;
    bit   m_acc;
    ref_t m_ref;

    // Scoreboard: check the stored state, then apply this cycle's transfers
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            armed = 1'b1;
        end else if (armed) begin
            chk("mon_out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("mon_in_ready", 64'(in_ready), 64'(q.size() < 2));
            if (out_valid && q.size() > 0)
                chk("mon_entry", 64'({imm_out, imm_fmt, imm_illegal, out_tag}), 64'(q[0]));
            m_acc = in_valid && q.size() < 2;
            if (flush) q.delete();
            else begin
                if (out_ready && q.size() > 0) void'(q.pop_front());
                if (m_acc) begin
                    m_ref = model(inst_code, 1'b0);
                    q.push_back('{imm: m_ref.imm[31:0], fmt: m_ref.fmt, ill: m_ref.ill, tag: in_tag});
                end
            end
        end
    end

    typedef struct {
        logic [31:0] inst;
        logic [31:0] e32;
        logic [63:0] e64;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6F, 7'h67, 7'h73, 7'h33, 7'h0F, 7'h7F};

    initial begin
        vec_t tbl[$];
        logic [31:0] r;
        tbl.push_back('{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0});
        tbl.push_back('{32'hFFDFF06F, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd6, 1'b0});
        tbl.push_back('{32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd4, 1'b0});
        tbl.push_back('{32'h00512423, 32'h00000008, 64'h0000000000000008, 3'd3, 1'b0});
        tbl.push_back('{32'h12345037, 32'h12345000, 64'h0000000012345000, 3'd5, 1'b0});
        tbl.push_back('{32'h00309093, 32'h00000003, 64'h0000000000000003, 3'd2, 1'b0});
        tbl.push_back('{32'h0000007F, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b1});
        tbl.push_back('{32'h03F09093, 32'h0000001F, 64'h000000000000003F, 3'd2, 1'b0});
        tbl.push_back('{32'h80000037, 32'h80000000, 64'hFFFFFFFF80000000, 3'd5, 1'b0});
        tbl.push_back('{32'h4030D093, 32'h00000003, 64'h0000000000000003, 3'd2, 1'b0});
        tbl.push_back('{32'hFFC52503, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0});
        tbl.push_back('{32'hFFFFF297, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 3'd5, 1'b0});
        tbl.push_back('{32'h00008067, 32'h00000000, 64'h0000000000000000, 3'd1, 1'b0});
        tbl.push_back('{32'h00000033, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b0});
        tbl.push_back('{32'h0000000F, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b0});
`ifdef IMM_ZICSR_EN
        tbl.push_back('{32'h0002D073, 32'h00000005, 64'h0000000000000005, 3'd7, 1'b0});
`else
        tbl.push_back('{32'h0002D073, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b0});
`endif
        tbl.push_back('{32'h34029073, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b0});

        repeat (3) step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_imm", 64'(imm_out), 64'd0);
        chk("rst_fmt", 64'(imm_fmt), 64'd0);
        chk("rst_illegal", 64'(imm_illegal), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_imm64", imm_out64, 64'd0);
        reset = 1'b0;

        out_ready = 1'b1;
        foreach (tbl[k]) begin
            in_valid = 1'b1;
            inst_code = tbl[k].inst;
            in_tag = 5'(k);
            step();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("tbl%0d_imm", k), 64'(imm_out), 64'(tbl[k].e32));
            chk($sformatf("tbl%0d_fmt", k), 64'(imm_fmt), 64'(tbl[k].fmt));
            chk($sformatf("tbl%0d_illegal", k), 64'(imm_illegal), 64'(tbl[k].ill));
            chk($sformatf("tbl%0d_tag", k), 64'(out_tag), 64'(k[4:0]));
            chk($sformatf("tbl%0d_imm64", k), imm_out64, tbl[k].e64);
            chk($sformatf("tbl%0d_fmt64", k), 64'(imm_fmt64), 64'(tbl[k].fmt));
            chk($sformatf("tbl%0d_rdy64", k), 64'({out_valid64, in_ready64, out_tag64}), 64'({2'b11, k[4:0]}));
        end
        repeat (2) step();

        // Backpressure: A then B while the consumer stalls
        out_ready = 1'b0;
        in_valid = 1'b1;
        inst_code = 32'h00100093;
        in_tag = 5'd1;
        step();
        chk("bp_ready_before_b", 64'(in_ready), 64'd1);
        inst_code = 32'h00200093;
        in_tag = 5'd2;
        step();
        in_valid = 1'b0;
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_imm_a", 64'(imm_out), 64'd1);
        step();
        chk("bp_hold_imm", 64'(imm_out), 64'd1);
        chk("bp_hold_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        chk("bp_imm_b", 64'(imm_out), 64'd2);
        chk("bp_valid_b", 64'(out_valid), 64'd1);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        step();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Flush with both entries full and a pending input
        out_ready = 1'b0;
        in_valid = 1'b1;
        inst_code = 32'h00500093;
        step();
        inst_code = 32'h00600093;
        step();
        chk("fl_full", 64'(in_ready), 64'd0);
        inst_code = 32'h00700093;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        // Flush with only main full, so the same-cycle input would have been accepted
        inst_code = 32'h00800093;
        step();
        inst_code = 32'h00900093;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl2_valid", 64'(out_valid), 64'd0);
        chk("fl2_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            chk("fl_stays_empty", 64'(out_valid), 64'd0);
        end

        for (int c = 0; c < 800; c++) begin
            r = $urandom;
            r[6:0] = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) r[6:0] = 7'($urandom);
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 39) == 0;
            inst_code = r;
            in_tag = 5'($urandom);
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
